// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (master 0 = CPU, master 1 = DMA): same-cycle grant and forwarding, read data routed to its owner one cycle later.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin with bounded lock retention; default build is fixed priority (master 0 wins).
module bus_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_m0_addr,
    input  logic        i_m0_rd,
    input  logic        i_m0_wr,
    input  logic [15:0] i_m0_wrdata,
    input  logic        i_m0_lock,
    output logic [15:0] o_m0_rddata,
    output logic        o_m0_wait,
    input  logic [15:0] i_m1_addr,
    input  logic        i_m1_rd,
    input  logic        i_m1_wr,
    input  logic [15:0] i_m1_wrdata,
    input  logic        i_m1_lock,
    output logic [15:0] o_m1_rddata,
    output logic        o_m1_wait,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wrdata,
    output logic        o_bus_rd,
    output logic        o_bus_wr,
    input  logic [15:0] i_bus_rddata,
    output logic [1:0]  o_grant
);
    logic req0, req1;
    logic gnt0, gnt1;
    logic rd_pend_vld, rd_pend_owner;

    assign req0 = i_m0_rd | i_m0_wr;
    assign req1 = i_m1_rd | i_m1_wr;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic       last_gnt;
    logic       held_vld, held_id;
    logic       lock_run;
    logic [2:0] lock_cnt;
    logic       held_req, lock_held, lock_expired, locked_gnt, sel1;

    // held_* remembers the master granted last cycle with its lock raised
    assign held_req     = held_id ? req1 : req0;
    assign lock_held    = held_vld & held_req;
    assign lock_expired = lock_held & lock_run & (lock_cnt == 3'd7) & req0 & req1;
    assign locked_gnt   = lock_held & ~lock_expired;

    always_comb begin
        sel1 = req1;
        if (req0 & req1) begin
            if (lock_held)
                sel1 = lock_expired ? ~held_id : held_id;
            else
                sel1 = ~last_gnt;
        end
    end

    assign gnt0 = req0 & ~sel1;
    assign gnt1 = req1 & sel1;

    // lock_cnt holds (locked grants in current run - 1) once lock_run is set
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_gnt <= 1'b1;
            held_vld <= 1'b0;
            held_id  <= 1'b0;
            lock_run <= 1'b0;
            lock_cnt <= 3'd0;
        end else begin
            if (gnt0 | gnt1)
                last_gnt <= gnt1;
            held_vld <= (gnt0 & i_m0_lock) | (gnt1 & i_m1_lock);
            held_id  <= gnt1;
            if (locked_gnt) begin
                lock_run <= 1'b1;
                if (!lock_run)
                    lock_cnt <= 3'd0;
                else if (lock_cnt != 3'd7)
                    lock_cnt <= lock_cnt + 3'd1;
            end else begin
                lock_run <= 1'b0;
                lock_cnt <= 3'd0;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = i_m0_lock | i_m1_lock;
    assign gnt0        = req0;
    assign gnt1        = req1 & ~req0;
`endif

    always_comb begin
        o_bus_addr   = '0;
        o_bus_wrdata = '0;
        o_bus_rd     = 1'b0;
        o_bus_wr     = 1'b0;
        if (gnt0) begin
            o_bus_addr   = i_m0_addr;
            o_bus_wrdata = i_m0_wrdata;
            o_bus_wr     = i_m0_wr;
            o_bus_rd     = i_m0_rd & ~i_m0_wr;
        end else if (gnt1) begin
            o_bus_addr   = i_m1_addr;
            o_bus_wrdata = i_m1_wrdata;
            o_bus_wr     = i_m1_wr;
            o_bus_rd     = i_m1_rd & ~i_m1_wr;
        end
    end

    assign o_grant   = {gnt1, gnt0};
    assign o_m0_wait = req0 & ~gnt0;
    assign o_m1_wait = req1 & ~gnt1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_pend_vld   <= 1'b0;
            rd_pend_owner <= 1'b0;
        end else begin
            rd_pend_vld   <= o_bus_rd;
            rd_pend_owner <= gnt1;
        end
    end

    assign o_m0_rddata = (rd_pend_vld & ~rd_pend_owner) ? i_bus_rddata : 16'h0000;
    assign o_m1_rddata = (rd_pend_vld &  rd_pend_owner) ? i_bus_rddata : 16'h0000;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have i_clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have i_reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have i_mN_addr  input  16  master N byte address (N=0,1; master 0 = CPU, master 1 = DMA).
REQ-004 SHALL have i_mN_rd / i_mN_wr  input  1 each  master N read / write strobes.
REQ-005 SHALL have i_mN_wrdata  input  16  master N write data.
REQ-006 SHALL have i_mN_lock  input  1  master N requests grant retention for the next access.
REQ-007 SHALL have o_mN_rddata  output  16  master N read data, valid one cycle after an accepted read.
REQ-008 SHALL have o_mN_wait  output  1  master N stalled; master holds addr/strobes/data while high.
REQ-009 SHALL have o_bus_addr, o_bus_wrdata  output  16  forwarded to the address-decoding bus.
REQ-010 SHALL have o_bus_rd, o_bus_wr  output  1  forwarded strobes.
REQ-011 SHALL have i_bus_rddata  input  16  bus read data, returned one cycle after o_bus_rd.
REQ-012 SHALL have o_grant  output  2  one-hot current grant (bit N = master N), 0 when idle.

Function
REQ-013 Request from master N SHALL be req_N = i_mN_rd | i_mN_wr.
REQ-014 Arbitration SHALL be combinational per cycle; the granted master's addr/wrdata/strobes SHALL drive the bus in the same cycle, with zero added latency.
REQ-015 Non-granted requesting master SHALL see o_mN_wait=1; a granted or idle master SHALL see o_mN_wait=0.
REQ-016 With no request, o_bus_* and o_grant SHALL be 0.
REQ-017 Master asserting rd and wr together SHALL be forwarded as a write only (o_bus_rd=0).
REQ-018 A 1-bit last-grant register SHALL update to N on every cycle master N is granted.
REQ-019 On contention, the master that is not last-grant SHALL be granted (round-robin), unless a lock is held (REQ-020).
REQ-020 Lock: if master N was granted last cycle with i_mN_lock=1 and req_N=1 this cycle, N SHALL be granted again regardless of the other request.
REQ-021 A 3-bit lock counter SHALL count consecutive lock-held grants; after 8 consecutive locked grants with the other master requesting, the lock SHALL be ignored for one cycle and the other master granted; the counter SHALL clear on any non-locked grant or idle cycle.
REQ-022 A pending-read register (valid + owner id) SHALL capture each forwarded read; next cycle o_mOwner_rddata = i_bus_rddata, all other rddata outputs = 0.
REQ-023 Back-to-back reads by alternating masters SHALL each return data to the correct owner with no bubble.
REQ-024 Write acceptance SHALL complete in the granted cycle; no write response exists.

Reset
REQ-025 On i_reset: last-grant = 1 (master 0 wins first contention), lock counter = 0, pending-read valid = 0.
REQ-026 During and immediately after reset, all o_*rddata SHALL be 0; a read in flight at reset SHALL be discarded.
REQ-027 Combinational outputs (o_bus_*, o_grant, o_mN_wait) SHALL follow REQ-014..REQ-019 from the first cycle after reset deassertion.

Configuration
REQ-028 Macro BUS_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-018..REQ-021.
REQ-029 Macro BUS_ARB_ROUND_ROBIN_EN undefined: fixed priority, master 0 always wins contention, lock and lock counter removed (i_mN_lock ignored), last-grant register absent; REQ-022 unchanged.

Verification
REQ-030 m0 rd addr 0x0010 alone -> o_bus_rd=1, o_bus_addr=0x0010, o_grant=01; next cycle i_bus_rddata=0xBEEF -> o_m0_rddata=0xBEEF, o_m1_rddata=0.
REQ-031 After reset, m0 wr 0x3000 data 0x00A5 and m1 rd 0x2000 same cycle -> m0 granted, o_m1_wait=1; next cycle m1 granted, read data routed to m1.
REQ-032 Both masters request continuously with no lock for 6 cycles -> grants alternate 01,10,01,10,01,10 (RR build); fixed-priority build -> 01 every cycle, o_m1_wait=1 throughout.
REQ-033 m1 holds lock with continuous requests while m0 requests -> m1 granted 9 cycles (initial + 8 locked), m0 granted on cycle 10.
REQ-034 m0 rd granted, i_reset pulsed before the data cycle -> o_m0_rddata=0 and pending-read cleared; m0 rd=1 wr=1 -> o_bus_wr=1, o_bus_rd=0.
